// File: rtl/mdu_scheduler_pkg.sv
// mdu_scheduler_pkg
//   Shared definitions for the multiclock M-extension issue controller:
//   default ALU latency / watchdog slack, the alucode values understood by
//   multiclockalu, and the scheduler state encoding.
package mdu_scheduler_pkg;

  localparam int unsigned LAT_DEF  = 6;
  localparam int unsigned WDOG_DEF = 2;

  localparam logic [5:0] ALU_MUL    = 6'd32;
  localparam logic [5:0] ALU_MULH   = 6'd33;
  localparam logic [5:0] ALU_MULHSU = 6'd34;
  localparam logic [5:0] ALU_MULHU  = 6'd35;
  localparam logic [5:0] ALU_DIV    = 6'd36;
  localparam logic [5:0] ALU_DIVU   = 6'd37;
  localparam logic [5:0] ALU_REM    = 6'd38;
  localparam logic [5:0] ALU_REMU   = 6'd39;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_scheduler_if.sv
// mdu_scheduler_if
//   Issue handshake from decode to the multiclock scheduler.
//   master: decode side (drives valid + operation), slave: scheduler side.
//   iss_valid/iss_ready : handshake, transfer when both high at a rising edge
//   iss_alucode, iss_op1, iss_op2, iss_rd : the operation being issued
interface mdu_scheduler_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_alucode;
  logic [31:0] iss_op1;
  logic [31:0] iss_op2;
  logic [4:0]  iss_rd;

  modport master (
    output iss_valid, iss_alucode, iss_op1, iss_op2, iss_rd,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_alucode, iss_op1, iss_op2, iss_rd,
    output iss_ready
  );
endinterface

// File: rtl/mdu_fixup.sv
// mdu_fixup
//   Combinational correction of the multiclock ALU result for the RISC-V
//   corner cases the ALU gets wrong: divide/remainder by zero, signed
//   division overflow, and MULHSU (the ALU returns the signed x signed
//   high word).
//   Ports: alucode/op1/op2 (latched operation), raw_result (ALU output),
//          fixed_result (architecturally correct value).
module mdu_fixup
  import mdu_scheduler_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] raw_result,
  output logic [31:0] fixed_result
);

  logic y_zero_s;
  logic ovf_s;

  // Operand classification shared by the division cases
  always_comb begin
    y_zero_s = (op2 == 32'h0000_0000);
    ovf_s    = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
  end

  // Per-opcode override of the raw ALU result
  always_comb begin
    fixed_result = raw_result;
    case (alucode)
      ALU_DIV: begin
        if (y_zero_s) begin
          fixed_result = 32'hFFFF_FFFF;
        end else if (ovf_s) begin
          fixed_result = 32'h8000_0000;
        end else begin
          fixed_result = raw_result;
        end
      end
      ALU_DIVU: begin
        if (y_zero_s) begin
          fixed_result = 32'hFFFF_FFFF;
        end else begin
          fixed_result = raw_result;
        end
      end
      ALU_REM: begin
        if (y_zero_s) begin
          fixed_result = op1;
        end else if (ovf_s) begin
          fixed_result = 32'h0000_0000;
        end else begin
          fixed_result = raw_result;
        end
      end
      ALU_REMU: begin
        if (y_zero_s) begin
          fixed_result = op1;
        end else begin
          fixed_result = raw_result;
        end
      end
      // signed(op1) * unsigned(op2) differs from the signed product by
      // op1 * 2^32 when op2[31] is set, i.e. +op1 on the high word.
      ALU_MULHSU: begin
        if (op2[31]) begin
          fixed_result = raw_result + op1;
        end else begin
          fixed_result = raw_result;
        end
      end
      default: fixed_result = raw_result;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler
//   Issue controller for the 6-stage multiclock M-extension ALU. Holds one
//   MUL/DIV/REM op stable for the whole ALU latency, flags RAW hazards
//   against the in-flight destination, owns the register-file write port
//   during writeback and fixes the ALU's RISC-V corner cases.
//   Ports:
//     clk, rst_n           : clock, synchronous active-low reset
//     iss                  : issue handshake (mdu_scheduler_if.slave)
//     kill                 : flush of the in-flight op
//     dec_rs1/dec_rs2, hazard : decode sources, stall request
//     mc_start, mc_alucode, mc_op1, mc_op2 : ALU inputs
//     mc_result, mc_done   : ALU outputs
//     wb_valid, wb_rd, wb_data : register-file write
//     pipe_wb_valid, pipe_stall : write-port arbitration with main pipe
//     err                  : sticky watchdog flag
module mdu_scheduler
  import mdu_scheduler_pkg::*;
#(
  parameter int unsigned LAT  = LAT_DEF,
  parameter int unsigned WDOG = WDOG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mdu_scheduler_if.slave     iss,
  input  logic               kill,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  output logic               hazard,
  output logic               mc_start,
  output logic [5:0]         mc_alucode,
  output logic [31:0]        mc_op1,
  output logic [31:0]        mc_op2,
  input  logic [31:0]        mc_result,
  input  logic               mc_done,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  input  logic               pipe_wb_valid,
  output logic               pipe_stall,
  output logic               err
);

  localparam logic [3:0] LAT_C = 4'(LAT);
  localparam logic [3:0] WD_C  = 4'(LAT + WDOG);

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic        killed_r;
  logic        err_r;
  logic        mc_start_r;
  logic [5:0]  alucode_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic [4:0]  rd_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic [31:0] fixed_s;
  logic        iss_ready_s;
  logic        hazard_s;
  logic        pipe_stall_s;

  mdu_fixup u_fixup (
    .alucode      (alucode_r),
    .op1          (op1_r),
    .op2          (op2_r),
    .raw_result   (mc_result),
    .fixed_result (fixed_s)
  );

  // Scheduler FSM, operand latches, latency/watchdog counter, writeback regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_DRAIN;
      cnt_r      <= LAT_C;
      killed_r   <= 1'b0;
      err_r      <= 1'b0;
      mc_start_r <= 1'b0;
      alucode_r  <= 6'd0;
      op1_r      <= 32'd0;
      op2_r      <= 32'd0;
      rd_r       <= 5'd0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
    end else begin
      mc_start_r <= 1'b0;
      wb_valid_r <= 1'b0;
      case (state_r)
        // The ALU has no reset: wait out one full latency so any op that
        // was in flight before reset has left the pipeline.
        ST_DRAIN: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_IDLE: begin
          if (iss.iss_valid && !kill) begin
            alucode_r  <= iss.iss_alucode;
            op1_r      <= iss.iss_op1;
            op2_r      <= iss.iss_op2;
            rd_r       <= iss.iss_rd;
            killed_r   <= 1'b0;
            cnt_r      <= 4'd1;
            mc_start_r <= 1'b1;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (kill) begin
            killed_r <= 1'b1;
          end
          if (mc_done) begin
            // A kill arriving in the completion cycle still suppresses WB.
            if (killed_r || kill) begin
              state_r <= ST_IDLE;
            end else begin
              state_r    <= ST_WB;
              wb_valid_r <= 1'b1;
              wb_rd_r    <= rd_r;
              wb_data_r  <= fixed_s;
            end
          end else if (cnt_r >= WD_C) begin
            err_r   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_WB: state_r <= ST_IDLE;
        default: state_r <= ST_DRAIN;
      endcase
    end
  end

  // Handshake, hazard and write-port arbitration (same-cycle responses)
  always_comb begin
    iss_ready_s  = 1'b0;
    hazard_s     = 1'b0;
    pipe_stall_s = 1'b0;
    if (state_r == ST_IDLE) begin
      iss_ready_s = !kill;
    end else begin
      iss_ready_s = 1'b0;
    end
    if (((state_r == ST_BUSY) || (state_r == ST_WB)) && !killed_r &&
        (rd_r != 5'd0) && ((dec_rs1 == rd_r) || (dec_rs2 == rd_r))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
    if (state_r == ST_WB) begin
      pipe_stall_s = pipe_wb_valid;
    end else begin
      pipe_stall_s = 1'b0;
    end
  end

  assign iss.iss_ready = iss_ready_s;
  assign hazard        = hazard_s;
  assign pipe_stall    = pipe_stall_s;
  assign mc_start      = mc_start_r;
  assign mc_alucode    = alucode_r;
  assign mc_op1        = op1_r;
  assign mc_op2        = op2_r;
  assign wb_valid      = wb_valid_r;
  assign wb_rd         = wb_rd_r;
  assign wb_data       = wb_data_r;
  assign err           = err_r;

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler
//   Self-checking bench for mdu_scheduler with a behavioural model of the
//   multiclock ALU (samples on the falling edge, raw RISC-V-incorrect
//   corner results) and a writeback scoreboard.
module tb_mdu_scheduler;
  import mdu_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  dec_rs1 = 5'd31;
  logic [4:0]  dec_rs2 = 5'd31;
  logic        hazard;
  logic        mc_start;
  logic [5:0]  mc_alucode;
  logic [31:0] mc_op1;
  logic [31:0] mc_op2;
  logic [31:0] mc_result = 32'd0;
  logic        mc_done = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pipe_wb_valid = 1'b0;
  logic        pipe_stall;
  logic        err;

  mdu_scheduler_if iss_if ();

  mdu_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iss           (iss_if),
    .kill          (kill),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .hazard        (hazard),
    .mc_start      (mc_start),
    .mc_alucode    (mc_alucode),
    .mc_op1        (mc_op1),
    .mc_op2        (mc_op2),
    .mc_result     (mc_result),
    .mc_done       (mc_done),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_stall    (pipe_stall),
    .err           (err)
  );

  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  logic [2:0]  alu_cnt = 3'd0;
  logic [31:0] alu_res = 32'd0;
  bit          alu_tie_low = 1'b0;

  function automatic logic [31:0] alu_raw(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ss;
    logic [63:0]        uu;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uu = {32'd0, a} * {32'd0, b};
    r  = 32'd0;
    case (c)
      ALU_MUL:    r = ss[31:0];
      ALU_MULH:   r = ss[63:32];
      ALU_MULHSU: r = ss[63:32];
      ALU_MULHU:  r = uu[63:32];
      ALU_DIV:    r = (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'h5A5A_5A5A : 32'(sa / sb);
      ALU_DIVU:   r = (b == 32'd0) ? 32'h5A5A_5A5A : a / b;
      ALU_REM:    r = (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'hA5A5_A5A5 : 32'(sa % sb);
      ALU_REMU:   r = (b == 32'd0) ? 32'hA5A5_A5A5 : a % b;
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (alu_tie_low) begin
      mc_done <= 1'b0;
      alu_cnt <= 3'd0;
    end else if (mc_start) begin
      alu_cnt <= 3'd5;
      alu_res <= alu_raw(mc_alucode, mc_op1, mc_op2);
      mc_done <= 1'b0;
    end else if (alu_cnt != 3'd0) begin
      alu_cnt <= alu_cnt - 3'd1;
      if (alu_cnt == 3'd1) begin
        mc_done   <= 1'b1;
        mc_result <= alu_res;
      end else begin
        mc_done <= 1'b0;
      end
    end else begin
      mc_done <= 1'b0;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t sb_q[$];

  typedef struct {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  logic [12:0] m_start, m_wb, m_ready, m_haz, m_stall, m_err, m_hold, m_zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at cycle 0 and observe cycles 0..12.
  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit expect_wb, input int kill_cyc, input int rst_cyc,
                        input int pw_lo, input int pw_hi, input logic [4:0] rs2);
    int  w;
    wb_t e;
    w = 0;
    while (!iss_if.iss_ready && w < 50) begin
      tick();
      w++;
    end
    if (!iss_if.iss_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    dec_rs2             = rs2;
    iss_if.iss_valid    = 1'b1;
    iss_if.iss_alucode  = code;
    iss_if.iss_op1      = a;
    iss_if.iss_op2      = b;
    iss_if.iss_rd       = rd;
    if (expect_wb) sb_q.push_back('{rd, exp});
    for (int c = 0; c <= 12; c++) begin
      if (c != 0) begin
        tick();
        iss_if.iss_valid = 1'b0;
        kill             = (c == kill_cyc);
        rst_n            = (c != rst_cyc);
        pipe_wb_valid    = (c >= pw_lo && c <= pw_hi);
      end
      #1;
      m_start[c] = mc_start;
      m_wb[c]    = wb_valid;
      m_ready[c] = iss_if.iss_ready;
      m_haz[c]   = hazard;
      m_stall[c] = pipe_stall;
      m_err[c]   = err;
      m_hold[c]  = (mc_alucode == code) && (mc_op1 == a) && (mc_op2 == b);
      m_zero[c]  = (mc_alucode == 6'd0) && (mc_op1 == 32'd0) && (mc_op2 == 32'd0);
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_unexpected_wb: got wb_valid=1 rd=%0d, expected none", tag, wb_rd);
        end else begin
          e = sb_q.pop_front();
          chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
          chk({tag, "_wb_data"}, wb_data, e.data);
        end
      end
    end
    kill          = 1'b0;
    rst_n         = 1'b1;
    pipe_wb_valid = 1'b0;
    dec_rs2       = 5'd31;
    chk({tag, "_wb_missing"}, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    iss_if.iss_valid   = 1'b0;
    iss_if.iss_alucode = 6'd0;
    iss_if.iss_op1     = 32'd0;
    iss_if.iss_op2     = 32'd0;
    iss_if.iss_rd      = 5'd0;

    vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'h8000_0000, 5'd6,  32'hFFFF_FFFF};
    vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'h8000_0000, 5'd7,  32'h7FFF_FFFF};
    vecs[3]  = '{ALU_DIV,    32'd100,        32'd0,         5'd8,  32'hFFFF_FFFF};
    vecs[4]  = '{ALU_REMU,   32'd100,        32'd0,         5'd9,  32'd100};
    vecs[5]  = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    vecs[6]  = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
    vecs[7]  = '{ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'd0};
    vecs[8]  = '{ALU_DIVU,   32'd100,        32'd7,         5'd14, 32'd14};
    vecs[9]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         5'd15, 32'hFFFF_FFFF};
    vecs[10] = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd16, 32'hFFFF_FFFF};
    vecs[11] = '{ALU_REM,    32'd100,        32'd0,         5'd17, 32'd100};
    vecs[12] = '{ALU_DIVU,   32'd100,        32'd0,         5'd18, 32'hFFFF_FFFF};

    // reset values
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_iss_ready", {31'd0, iss_if.iss_ready}, 32'd0);
    chk("rst_mc_start", {31'd0, mc_start}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mc_alucode", {26'd0, mc_alucode}, 32'd0);
    chk("rst_mc_op1", mc_op1, 32'd0);
    chk("rst_mc_op2", mc_op2, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!iss_if.iss_ready && n < 20) begin
      tick();
      n++;
    end
    chk("drain_cycles", n, 32'd6);

    // table-driven ops with full timing checks
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      run_op(t, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1, -1, -1, 99, 0, 5'd31);
      chk({t, "_mc_start"}, {19'd0, m_start}, {19'd0, 13'b0000000000010});
      chk({t, "_wb_valid"}, {19'd0, m_wb},    {19'd0, 13'b0000010000000});
      chk({t, "_iss_ready"}, {19'd0, m_ready}, {19'd0, 13'b1111100000001});
      chk({t, "_hold"}, {25'd0, m_hold[7:1]}, {25'd0, 7'h7F});
      chk({t, "_hazard"}, {19'd0, m_haz}, 32'd0);
    end

    // RAW hazard against rd=x10
    run_op("haz10", ALU_MUL, 32'd3, 32'd4, 5'd10, 32'd12, 1'b1, -1, -1, 99, 0, 5'd10);
    chk("haz10_mask", {19'd0, m_haz}, {19'd0, 13'b0000011111110});

    // rd=x0 never hazards
    run_op("haz0", ALU_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1, -1, -1, 99, 0, 5'd0);
    chk("haz0_mask", {19'd0, m_haz}, 32'd0);

    // write-port collision in cycles 6..8
    run_op("pipe", ALU_MUL, 32'd5, 32'd6, 5'd20, 32'd30, 1'b1, -1, -1, 6, 8, 5'd31);
    chk("pipe_stall_mask", {19'd0, m_stall}, {19'd0, 13'b0000010000000});

    // kill in cycle 3
    run_op("kill", ALU_MUL, 32'd5, 32'd6, 5'd21, 32'd30, 1'b0, 3, -1, 99, 0, 5'd31);
    chk("kill_wb_valid", {19'd0, m_wb}, 32'd0);
    chk("kill_iss_ready", {19'd0, m_ready}, {19'd0, 13'b1111110000001});

    // reset in cycle 3, stray mc_done in cycle 6
    run_op("rstmid", ALU_MUL, 32'd9, 32'd9, 5'd22, 32'd81, 1'b0, -1, 3, 99, 0, 5'd31);
    chk("rstmid_wb_valid", {19'd0, m_wb}, 32'd0);
    chk("rstmid_iss_ready", {19'd0, m_ready}, {19'd0, 13'b1110000000001});
    chk("rstmid_mc_zero", {23'd0, m_zero[12:4]}, {23'd0, 9'h1FF});

    // watchdog: ALU never completes
    alu_tie_low = 1'b1;
    run_op("wdog", ALU_DIVU, 32'd50, 32'd5, 5'd23, 32'd10, 1'b0, -1, -1, 99, 0, 5'd31);
    alu_tie_low = 1'b0;
    chk("wdog_err", {19'd0, m_err}, {19'd0, 13'b1111000000000});
    chk("wdog_iss_ready", {19'd0, m_ready}, {19'd0, 13'b1111000000001});
    chk("wdog_wb_valid", {19'd0, m_wb}, 32'd0);

    // err clears only on reset
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("err_cleared", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!iss_if.iss_ready && n < 20) begin
      tick();
      n++;
    end
    chk("drain_cycles_2", n, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Issue controller for the 6-stage multiclock M-extension ALU (`multiclockalu`). Accepts one MUL/DIV/REM operation at a time from decode and holds its operands and alucode stable for the whole latency. The ALU selects its result using its live alucode input, so ops cannot overlap. Also detects RAW hazards against the in-flight destination, arbitrates the single register-file write port against the main pipeline, and corrects the ALU's RISC-V corner cases: divide-by-zero, signed overflow and MULHSU.

## Interface
- `LAT`, 6: ALU latency in cycles from the `mc_start` cycle to `mc_done` being sampled.
- `WDOG`, 2: extra cycles past `LAT` before the op is declared lost.

Ports:
- `clk` in 1: single clock, rising edge; the ALU runs on the falling edge of the same clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `iss_valid` in 1, `iss_ready` out 1: issue handshake.
- `iss_alucode` in 6, `iss_op1` in 32, `iss_op2` in 32, `iss_rd` in 5: the operation being issued.
- `kill` in 1: flush of the in-flight op.
- `dec_rs1`, `dec_rs2` in 5: source registers of the instruction currently in decode.
- `hazard` out 1: decode must stall.
- `mc_start` out 1: drives the ALU's `is_multiclock_input`.
- `mc_alucode` out 6, `mc_op1` out 32, `mc_op2` out 32: ALU operands.
- `mc_result` in 32, `mc_done` in 1: ALU outputs.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out 32: register-file write.
- `pipe_wb_valid` in 1: the main pipeline wants the write port this cycle.
- `pipe_stall` out 1: main pipeline loses the write port.
- `err` out 1: sticky watchdog flag.

## Operation
- States: DRAIN, IDLE, BUSY, WB.
- DRAIN
  - Entered on reset.
  - Counter loads `LAT`; moves to IDLE when it reaches 0.
  - Flushes stale `is_working` bits, since the ALU has no reset.
- IDLE
  - `iss_ready = !kill`.
  - On accept: latch alucode, op1, op2 and rd; clear `killed`; go to BUSY.
- BUSY
  - `mc_start` is 1 in the first BUSY cycle only; the counter increments every cycle.
  - When `mc_done` is 1 at a rising edge: capture `mc_result`.
    - Go to WB if `!killed`, else to IDLE.
  - If the counter reaches `LAT+WDOG` without `mc_done`: set `err`, go to IDLE, no writeback.
- WB
  - `wb_valid=1`, `wb_rd`/`wb_data` from the latches, for one cycle; then go to IDLE.
  - `pipe_stall = pipe_wb_valid`: the multiclock result always has priority.
- `mc_done` is ignored in DRAIN, IDLE and WB.
- `mc_alucode`/`mc_op1`/`mc_op2` come from the latches.
  - They are held unchanged from the `mc_start` cycle through WB.
  - They read 0 in DRAIN.
- `hazard = (state∈{BUSY,WB}) && !killed && rd≠0 && (dec_rs1==rd || dec_rs2==rd)`. There is no bypass.
- `kill`:
  - In BUSY: sets `killed`.
  - In WB: ignored; the write commits.
  - In IDLE: blocks the same-cycle accept.
- Result fixup, applied to the captured result using the latched operands (y = op2):
  - DIV/DIVU with y==0 → 0xFFFFFFFF.
  - REM/REMU with y==0 → op1.
  - DIV with op1==0x80000000 and y==0xFFFFFFFF → 0x80000000.
  - REM with that same overflow pair → 0.
  - MULHSU → ALU_hi + (op2[31] ? op1 : 0), mod 2^32. This corrects the ALU's signed×signed high word.
  - All other codes pass through unchanged.

## Timing
- Cycle 0 is the accept edge. Per op:
  - Cycle 1: `mc_start=1`; the ALU samples at the falling edge in cycle 1.
  - `mc_done` rises mid-cycle 6 and is captured at the end of cycle 6.
  - Cycle 7: WB.
  - Cycle 8: IDLE.
- Minimum issue spacing is 8 cycles.
- A killed op returns to IDLE in cycle 7.
- Reset values:
  - state DRAIN, `killed=0`, `err=0`.
  - `iss_ready`, `mc_start`, `wb_valid`, `hazard`, `pipe_stall` all 0.
  - `wb_rd`, `wb_data`, `mc_*` all 0.
- Reset mid-BUSY or mid-WB: the op is dropped, no writeback, re-enter DRAIN.
  - A late `mc_done` from the dropped op is ignored.
  - `iss_ready` rises `LAT` cycles after `rst_n` goes high.
- `err` clears only on reset.

## Structure
- Alucode constants (`ALU_MUL` … `ALU_REMU`) and the state encoding live in the shared defines header used by `multiclockalu`.
- Sub-module `mdu_fixup`: combinational fixup; inputs alucode, op1, op2, raw result; output corrected result.
- FSM, latches and counter stay in `mdu_scheduler`.
- Target size: about 200 lines.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=x5, accepted at cycle 0 → `mc_start` in cycle 1 only; `wb_valid` in cycle 7 with rd=5 and data 0xFFFFFFEB; `iss_ready` high again in cycle 8.
- MULHSU op1=0xFFFFFFFF, op2=0x80000000 → `wb_data` 0xFFFFFFFF. MULHU with the same operands → 0x7FFFFFFF.
- DIV 100/0 → 0xFFFFFFFF; REMU 100%0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same pair → 0.
- Issue with rd=x10 and `dec_rs2`=10 → `hazard` high in cycles 1–7, low in cycle 8. Same issue with rd=x0 → `hazard` never asserts.
- Two collision and flush cases:
  - `pipe_wb_valid=1` in cycles 6–8 → `pipe_stall` high only in cycle 7.
  - `kill` in cycle 3 → no `wb_valid`; `iss_ready` high in cycle 7.
- Two reset and watchdog cases:
  - `rst_n` low in cycle 3, then high → stray `mc_done` ignored; no writeback; ready 6 cycles after release.
  - `mc_done` tied low → `err=1` once the counter reaches 8; FSM returns to IDLE.
